// File: rtl/apb_pkg.sv
// apb_pkg: FSM encodings, bus widths and the captured request bundle.
// Shared by apb_slave_regfile and apb_reg_bank.
package apb_pkg;

  localparam int APB_DW  = 32;
  localparam int APB_AW  = 32;
  localparam int WAIT_CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_st_e;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic              write;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: NUM_REGS x 32-bit register array with one write port.
// With APB_SLV_PSLVERR_EN the last slot is a transfer counter.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
`ifdef APB_SLV_PSLVERR_EN
  input  logic                       inc_i,
`endif
  input  logic [IW-1:0]              idx_i,
  input  logic [APB_DW-1:0]          wdata_i,
  output logic [APB_DW-1:0]          rdata_o,
  output logic [NUM_REGS*APB_DW-1:0] regs_o
);

  logic [APB_DW-1:0] mem_q [NUM_REGS];

  // register storage: write port, plus status count in the last slot
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
`ifdef APB_SLV_PSLVERR_EN
      if (inc_i) begin
        mem_q[NUM_REGS-1] <= mem_q[NUM_REGS-1] + 32'd1;
      end
`endif
    end
  end

  assign rdata_o = mem_q[idx_i];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*APB_DW +: APB_DW] = mem_q[g];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with wait states and a flat reg export.
// Optional macro APB_SLV_PSLVERR_EN: pslverr on misses, RO status reg.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                SEL_IDX     = 0,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                       pclk,
  input  logic                       prst,
  input  logic [1:0]                 pselx,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [APB_AW-1:0]          paddr,
  input  logic [APB_DW-1:0]          pwdata,
  output logic                       pready,
  output logic [APB_DW-1:0]          prdata,
  output logic                       pslverr,
  output logic [NUM_REGS*APB_DW-1:0] regs_q
);

  localparam int IW    = $clog2(NUM_REGS);
  localparam int LIM_W = APB_AW + 1;
  localparam logic [LIM_W-1:0] LIMIT =
    {1'b0, BASE_ADDR} + LIM_W'(4 * NUM_REGS);
  localparam logic [1:0] SEL_MASK = 2'b01 << SEL_IDX;
  localparam logic [WAIT_CW-1:0] WAIT_INIT = WAIT_CW'(WAIT_CYCLES);

  apb_st_e            state_q, state_d;
  apb_req_t           req_q, req_d;
  logic [WAIT_CW-1:0] cnt_q, cnt_d;
  logic               pready_q, pready_d;
  logic [APB_DW-1:0]  prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;

  logic              detect;
  logic              fire;
  logic              hit;
  logic [IW-1:0]     idx;
  logic              we;
  logic              err;
  logic [APB_DW-1:0] rdata;

  assign detect = |(pselx & SEL_MASK) & penable;
  assign fire   = (state_q == ST_WAIT) && (cnt_q == '0);
  assign hit    = (req_q.addr >= BASE_ADDR) &&
                  ({1'b0, req_q.addr} < LIMIT);
  assign idx    = req_q.addr[2 +: IW];

`ifdef APB_SLV_PSLVERR_EN
  logic ro_wr;
  assign ro_wr = req_q.write && (idx == IW'(NUM_REGS-1));
  assign we    = fire && req_q.write && hit && !ro_wr;
  assign err   = !hit || ro_wr;
`else
  assign we    = fire && req_q.write && hit;
  assign err   = 1'b0;
`endif

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_bank (
    .clk_i   (pclk),
    .rst_ni  (prst),
    .we_i    (we),
`ifdef APB_SLV_PSLVERR_EN
    .inc_i   (fire),
`endif
    .idx_i   (idx),
    .wdata_i (req_q.wdata),
    .rdata_o (rdata),
    .regs_o  (regs_q)
  );

  // state register
  always_ff @(posedge pclk) begin
    if (!prst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state: detect, count down, one response cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (detect) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // output/datapath next values per state
  always_comb begin
    req_d     = req_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (detect) begin
          req_d = '{addr: paddr, write: pwrite, wdata: pwdata};
          cnt_d = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CW'(1);
        end else begin
          pready_d  = 1'b1;
          prdata_d  = (!req_q.write && hit) ? rdata : '0;
          pslverr_d = err;
        end
      end
      default: begin
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  // output and capture registers
  always_ff @(posedge pclk) begin
    if (!prst) begin
      req_q     <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: two slaves on a shared APB bus vs a memory model.
// Honours APB_SLV_PSLVERR_EN when the build defines it.
module tb_apb_slave_regfile;

  localparam logic [31:0] B0 = 32'h0000_1000;
  localparam logic [31:0] B1 = 32'h0000_2000;
  localparam int N0 = 8;
  localparam int N1 = 4;
  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic [1:0]  pselx = 2'b00;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic            rdy0, rdy1, err0, err1;
  logic [31:0]     rd0, rd1;
  logic [N0*32-1:0] rq0;
  logic [N1*32-1:0] rq1;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [2][8];

  always #5 pclk = ~pclk;

  apb_slave_regfile #(
    .SEL_IDX(0), .BASE_ADDR(B0), .NUM_REGS(N0), .WAIT_CYCLES(W0)
  ) dut0 (
    .pclk(pclk), .prst(prst), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy0), .prdata(rd0), .pslverr(err0), .regs_q(rq0)
  );

  apb_slave_regfile #(
    .SEL_IDX(1), .BASE_ADDR(B1), .NUM_REGS(N1), .WAIT_CYCLES(W1)
  ) dut1 (
    .pclk(pclk), .prst(prst), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy1), .prdata(rd1), .pslverr(err1), .regs_q(rq1)
  );

  function automatic int nregs(input int s);
    return (s != 0) ? N1 : N0;
  endfunction

  function automatic logic [31:0] base(input int s);
    return (s != 0) ? B1 : B0;
  endfunction

  function automatic int wt(input int s);
    return (s != 0) ? W1 : W0;
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [N0*32-1:0] e0;
    logic [N1*32-1:0] e1;
    for (int i = 0; i < N0; i++) e0[i*32 +: 32] = mdl[0][i];
    for (int i = 0; i < N1; i++) e1[i*32 +: 32] = mdl[1][i];
    chk({tag, "_regs0"}, 256'(rq0), 256'(e0));
    chk({tag, "_regs1"}, 256'(rq1), 256'(e1));
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) mdl[s][i] = '0;
  endtask

  // one APB transfer to slave s; caller sits 1 time unit past an edge
  task automatic xfer(input int s, input logic wr,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input bit scramble);
    int n, idx, lat;
    bit hit, done, other, early;
    logic [31:0] rexp, rgot;
    logic eexp, egot, rdy;
    n    = nregs(s);
    hit  = (addr >= base(s)) && (addr < base(s) + 32'(4*n));
    idx  = int'((addr >> 2) % 32'(n));
    eexp = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
    eexp = !hit || (wr && idx == n-1);
`endif
    rexp = (!wr && hit) ? mdl[s][idx] : 32'h0;
    pselx    = 2'b00;
    pselx[s] = 1'b1;
    penable  = 1'b1;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wd;
    lat = 0; done = 0; other = 0; early = 0;
    rgot = '0; egot = 1'b0;
    while (!done && lat < 30) begin
      @(posedge pclk); #1;
      lat++;
      if ((s == 0) ? rdy1 : rdy0) other = 1;
      rdy = (s == 0) ? rdy0 : rdy1;
      if (rdy) begin
        done = 1;
        rgot = (s == 0) ? rd0 : rd1;
        egot = (s == 0) ? err0 : err1;
      end else begin
        if (((s == 0) ? rd0 : rd1) != 0) early = 1;
        if (scramble) begin
          paddr  = $urandom;
          pwdata = $urandom;
          pselx  = 2'b00;
        end
      end
    end
    chk("latency", 256'(lat), 256'(wt(s) + 2));
    chk("prdata", 256'(rgot), 256'(rexp));
    chk("pslverr", 256'(egot), 256'(eexp));
    chk("prdata_early", 256'(early), 256'(0));
    pselx   = 2'b00;
    penable = 1'b0;
    if (wr && hit) begin
`ifdef APB_SLV_PSLVERR_EN
      if (idx != n-1) mdl[s][idx] = wd;
`else
      mdl[s][idx] = wd;
`endif
    end
`ifdef APB_SLV_PSLVERR_EN
    mdl[s][n-1] = mdl[s][n-1] + 1;
`endif
    @(posedge pclk); #1;
    rdy = (s == 0) ? rdy0 : rdy1;
    chk("pready_width", 256'(rdy), 256'(0));
    chk("prdata_clear", 256'((s == 0) ? rd0 : rd1), 256'(0));
    chk("other_pready", 256'(other), 256'(0));
    chk_regs("post_xfer");
  endtask

  initial begin
    int s, n, k;
    logic wr;
    logic [31:0] a;
    bit stray;
    clear_model();

    // reset held for 3 cycles
    prst = 1'b0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b1;
    chk("rst_pready", 256'({rdy0, rdy1}), 256'(0));
    chk("rst_pslverr", 256'({err0, err1}), 256'(0));
    chk("rst_prdata", 256'({rd0, rd1}), 256'(0));
    chk_regs("rst");

    // zero-wait write, then 3-wait write and read back
    xfer(0, 1'b1, B0 + 32'd4, 32'hDEAD_BEEF, 1'b0);
    chk("t2_reg1", 256'(rq0[63:32]), 256'(32'hDEAD_BEEF));
    xfer(1, 1'b1, B1 + 32'd4, 32'hDEAD_BEEF, 1'b0);
    xfer(1, 1'b0, B1 + 32'd4, 32'h0, 1'b0);

    // other select line only: dut0 address through dut1's select
    xfer(1, 1'b1, B0 + 32'd4, 32'h1234_5678, 1'b0);

    // out of range and last register
    xfer(0, 1'b1, B0 + 32'(4*N0), 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b1, B0 + 32'(4*(N0-1)), 32'h5A5A_0001, 1'b0);
    xfer(0, 1'b0, B0 + 32'(4*(N0-1)), 32'h0, 1'b0);
    xfer(1, 1'b0, B1 - 32'd4, 32'h0, 1'b0);

    // reset during the wait phase of a write
    pselx   = 2'b10;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = B1;
    pwdata  = 32'hCAFE_F00D;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    prst    = 1'b0;
    pselx   = 2'b00;
    penable = 1'b0;
    stray   = 0;
    repeat (2) begin
      @(posedge pclk); #1;
      if (rdy1 || rdy0) stray = 1;
    end
    prst = 1'b1;
    clear_model();
    chk("t6_no_pready", 256'(stray), 256'(0));
    chk("t6_reg0", 256'(rq1[31:0]), 256'(0));
    chk_regs("t6");
    xfer(1, 1'b1, B1, 32'hCAFE_F00D, 1'b0);
    xfer(1, 1'b0, B1, 32'h0, 1'b0);

    // randomized traffic, with bus scrambling during wait states
    for (int it = 0; it < 60; it++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      n  = nregs(s);
      k  = int'($urandom_range(0, 9));
      if (k == 0)
        a = base(s) + 32'(4*n) + 32'(4*$urandom_range(0, 3));
      else if (k == 1)
        a = base(s) - 32'd4;
      else
        a = base(s) + 32'(4*$urandom_range(0, n-1)) +
            32'($urandom_range(0, 3));
      xfer(s, wr, a, $urandom, 1'($urandom_range(0, 1)));
      if (wr && $urandom_range(0, 1) == 1)
        xfer(s, 1'b0, a, 32'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
